// File: rtl/io_bus_arbiter.sv
// -----------------------------------------------------------------------------
// io_bus_arbiter
//
// Shares the single IO_Handler register bus (io_addr/io_write/io_read/
// io_wdata/io_rdata) among NUM_REQ requesters.  Every granted request produces
// exactly one single-cycle bus strobe, read data is captured one cycle after
// the read strobe, and the winner receives a one-cycle acknowledge.
//
// Build option:
//   IO_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins,
//                                      no round-robin pointer.
//                         undefined -> round-robin arbitration (default).
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   ADDR_W   IO_Handler register address width
//   DATA_W   register data width
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   req        in   [NUM_REQ]         per-requester request level
//   req_we     in   [NUM_REQ]         1 = write, 0 = read
//   req_addr   in   [NUM_REQ*ADDR_W]  flattened addresses, i at [i*ADDR_W +: ADDR_W]
//   req_wdata  in   [NUM_REQ*DATA_W]  flattened write data, same packing
//   gnt        out  [NUM_REQ]         one-hot grant, ISSUE through DONE
//   ack        out  [NUM_REQ]         one-hot one-cycle completion pulse
//   rdata      out  [DATA_W]          captured read data, held until next read
//   busy       out                    high whenever the FSM is not IDLE
//   io_addr    out  [ADDR_W]          bus address (holds last value in IDLE)
//   io_write   out                    bus write strobe
//   io_read    out                    bus read strobe
//   io_wdata   out  [DATA_W]          bus write data (holds last value in IDLE)
//   io_rdata   in   [DATA_W]          bus read data, valid one cycle after io_read
// -----------------------------------------------------------------------------
module io_bus_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          ack,
    output logic [DATA_W-1:0]           rdata,
    output logic                        busy,
    output logic [ADDR_W-1:0]           io_addr,
    output logic                        io_write,
    output logic                        io_read,
    output logic [DATA_W-1:0]           io_wdata,
    input  logic [DATA_W-1:0]           io_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // One-hot decode of a requester index.
    function automatic logic [NUM_REQ-1:0] onehot_f(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // -------------------------------------------------------------------------
    // Registers and next-state signals
    // -------------------------------------------------------------------------
    state_t               state_r,    state_nxt_s;
    logic [IDX_W-1:0]     winner_r,   winner_nxt_s;
    logic                 we_r,       we_nxt_s;
    logic [NUM_REQ-1:0]   gnt_r,      gnt_nxt_s;
    logic [NUM_REQ-1:0]   ack_r,      ack_nxt_s;
    logic [DATA_W-1:0]    rdata_r,    rdata_nxt_s;
    logic                 busy_r,     busy_nxt_s;
    logic [ADDR_W-1:0]    io_addr_r,  io_addr_nxt_s;
    logic [DATA_W-1:0]    io_wdata_r, io_wdata_nxt_s;
    logic                 io_write_r, io_write_nxt_s;
    logic                 io_read_r,  io_read_nxt_s;

    // Arbitration result for the current cycle (only consumed in IDLE).
    logic [IDX_W-1:0]     winner_s;

    // Per-requester views of the flattened address / data buses.
    logic [ADDR_W-1:0]    addr_arr_s  [NUM_REQ];
    logic [DATA_W-1:0]    wdata_arr_s [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr_s[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr_s[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef IO_ARB_FIXED_PRIO_EN
    // Fixed priority: scan from the highest index down so the lowest set
    // request is the last (and therefore winning) assignment.
    always_comb begin
        winner_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            winner_s = req[k] ? IDX_W'(k) : winner_s;
        end
    end
`else
    logic [IDX_W-1:0] ptr_r;

    // Round-robin: offset k = 0 is the pointer itself and has top priority,
    // so scan offsets from farthest to nearest and let the nearest win.
    always_comb begin
        int idx_v;
        idx_v    = 0;
        winner_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_v    = (int'(ptr_r) + k) % NUM_REQ;
            winner_s = req[idx_v] ? IDX_W'(idx_v) : winner_s;
        end
    end

    // Round-robin pointer: moves to the slot after the winner as DONE retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= '0;
        end else if (state_r == ST_DONE) begin
            ptr_r <= (winner_r == IDX_W'(NUM_REQ - 1)) ? '0 : winner_r + 1'b1;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`endif

    // Next-state and next-output logic.  Every output is registered, so the
    // values computed here for a transition appear in the destination state.
    always_comb begin
        state_nxt_s    = state_r;
        winner_nxt_s   = winner_r;
        we_nxt_s       = we_r;
        gnt_nxt_s      = gnt_r;
        ack_nxt_s      = '0;
        rdata_nxt_s    = rdata_r;
        io_addr_nxt_s  = io_addr_r;
        io_wdata_nxt_s = io_wdata_r;
        io_write_nxt_s = 1'b0;
        io_read_nxt_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    // Requester inputs are captured only here; later changes
                    // (including dropping req) cannot affect the transaction.
                    winner_nxt_s   = winner_s;
                    we_nxt_s       = req_we[winner_s];
                    gnt_nxt_s      = onehot_f(winner_s);
                    io_addr_nxt_s  = addr_arr_s[winner_s];
                    io_wdata_nxt_s = wdata_arr_s[winner_s];
                    io_write_nxt_s = req_we[winner_s];
                    io_read_nxt_s  = ~req_we[winner_s];
                    state_nxt_s    = ST_ISSUE;
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // The strobe is live this cycle; a write completes next cycle,
                // a read needs one more cycle for io_rdata to become valid.
                if (we_r) begin
                    ack_nxt_s   = onehot_f(winner_r);
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                rdata_nxt_s = io_rdata;
                ack_nxt_s   = onehot_f(winner_r);
                state_nxt_s = ST_DONE;
            end
            ST_DONE: begin
                gnt_nxt_s   = '0;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                gnt_nxt_s   = '0;
                state_nxt_s = ST_IDLE;
            end
        endcase

        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            winner_r   <= '0;
            we_r       <= 1'b0;
            gnt_r      <= '0;
            ack_r      <= '0;
            rdata_r    <= '0;
            busy_r     <= 1'b0;
            io_addr_r  <= '0;
            io_wdata_r <= '0;
            io_write_r <= 1'b0;
            io_read_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            winner_r   <= winner_nxt_s;
            we_r       <= we_nxt_s;
            gnt_r      <= gnt_nxt_s;
            ack_r      <= ack_nxt_s;
            rdata_r    <= rdata_nxt_s;
            busy_r     <= busy_nxt_s;
            io_addr_r  <= io_addr_nxt_s;
            io_wdata_r <= io_wdata_nxt_s;
            io_write_r <= io_write_nxt_s;
            io_read_r  <= io_read_nxt_s;
        end
    end

    assign gnt      = gnt_r;
    assign ack      = ack_r;
    assign rdata    = rdata_r;
    assign busy     = busy_r;
    assign io_addr  = io_addr_r;
    assign io_wdata = io_wdata_r;
    assign io_write = io_write_r;
    assign io_read  = io_read_r;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_io_bus_arbiter
//
// Directed bench for io_bus_arbiter with four requesters.  Inputs change and
// outputs are sampled on the falling clock edge; a small register-file model
// answers reads one cycle after io_read.
// -----------------------------------------------------------------------------
module tb_io_bus_arbiter;

    localparam int NR = 4;
    localparam int AW = 4;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     ack;
    logic [DW-1:0]     rdata;
    logic              busy;
    logic [AW-1:0]     io_addr;
    logic              io_write;
    logic              io_read;
    logic [DW-1:0]     io_wdata;
    logic [DW-1:0]     io_rdata;

    logic [DW-1:0]     mem [16];
    logic [NR-1:0]     rr_exp;

    int checks   = 0;
    int failures = 0;

    io_bus_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy),
        .io_addr   (io_addr),
        .io_write  (io_write),
        .io_read   (io_read),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata)
    );

    always #5 clk = ~clk;

    // IO_Handler read model: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (io_read) io_rdata <= mem[io_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        io_rdata  = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[1]    = 8'h3C;
        mem[3]    = 8'h96;
        reset     = 1'b1;
        req       = 4'b0000;
        req_we    = 4'b0000;
        req_addr  = 16'h0000;
        req_wdata = 32'h0000_0000;

        // ---- reset values ----
        repeat (2) @(negedge clk);
        chk("rst_gnt",    32'(gnt),      32'h0);
        chk("rst_ack",    32'(ack),      32'h0);
        chk("rst_busy",   32'(busy),     32'h0);
        chk("rst_wr",     32'(io_write), 32'h0);
        chk("rst_rd",     32'(io_read),  32'h0);
        chk("rst_addr",   32'(io_addr),  32'h0);
        chk("rst_wdata",  32'(io_wdata), 32'h0);
        chk("rst_rdata",  32'(rdata),    32'h0);
        reset = 1'b0;

        // ---- single write, requester 0 (pointer 0 -> 1) ----
        @(negedge clk);
        req[0]               = 1'b1;
        req_we[0]            = 1'b1;
        req_addr[0*AW +: AW]  = 4'h2;
        req_wdata[0*DW +: DW] = 8'hA5;
        @(negedge clk);                                  // cycle 1: ISSUE
        chk("wr_strobe",  32'(io_write), 32'h1);
        chk("wr_nord",    32'(io_read),  32'h0);
        chk("wr_addr",    32'(io_addr),  32'h2);
        chk("wr_wdata",   32'(io_wdata), 32'hA5);
        chk("wr_gnt",     32'(gnt),      32'h1);
        chk("wr_busy",    32'(busy),     32'h1);
        chk("wr_noack1",  32'(ack),      32'h0);
        @(negedge clk);                                  // cycle 2: DONE
        chk("wr_strobe1", 32'(io_write), 32'h0);
        chk("wr_ack",     32'(ack),      32'h1);
        chk("wr_gnt2",    32'(gnt),      32'h1);
        chk("wr_rdata",   32'(rdata),    32'h0);
        req[0] = 1'b0;
        @(negedge clk);                                  // cycle 3: IDLE
        chk("wr_ackoff",  32'(ack),      32'h0);
        chk("wr_gntoff",  32'(gnt),      32'h0);
        chk("wr_idle",    32'(busy),     32'h0);
        chk("wr_hold",    32'(io_addr),  32'h2);

        // ---- single read, requester 1 (pointer 1 -> 2) ----
        req[1]               = 1'b1;
        req_we[1]            = 1'b0;
        req_addr[1*AW +: AW]  = 4'h1;
        @(negedge clk);                                  // cycle 1: ISSUE
        chk("rd_strobe",  32'(io_read),  32'h1);
        chk("rd_nowr",    32'(io_write), 32'h0);
        chk("rd_addr",    32'(io_addr),  32'h1);
        chk("rd_gnt",     32'(gnt),      32'h2);
        @(negedge clk);                                  // cycle 2: CAPTURE
        chk("rd_strobe1", 32'(io_read),  32'h0);
        chk("rd_noack",   32'(ack),      32'h0);
        chk("rd_busy",    32'(busy),     32'h1);
        @(negedge clk);                                  // cycle 3: DONE
        chk("rd_ack",     32'(ack),      32'h2);
        chk("rd_data",    32'(rdata),    32'h3C);
        req[1] = 1'b0;
        @(negedge clk);                                  // IDLE
        chk("rd_ackoff",  32'(ack),      32'h0);
        chk("rd_idle",    32'(busy),     32'h0);
        chk("rd_hold",    32'(rdata),    32'h3C);

        // ---- round robin: 0 and 1 both writing, pointer starts at 2 ----
        req_we[1:0]           = 2'b11;
        req_wdata[0*DW +: DW] = 8'h11;
        req_wdata[1*DW +: DW] = 8'h22;
        req[1:0]              = 2'b11;
        for (int t = 0; t < 4; t++) begin
`ifdef IO_ARB_FIXED_PRIO_EN
            rr_exp = 4'b0001;
`else
            rr_exp = (t % 2 == 0) ? 4'b0001 : 4'b0010;
`endif
            @(negedge clk);                              // ISSUE
            chk("rr_gnt",   32'(gnt),      32'(rr_exp));
            chk("rr_wdata", 32'(io_wdata), (rr_exp == 4'b0001) ? 32'h11 : 32'h22);
            @(negedge clk);                              // DONE
            chk("rr_ack",   32'(ack),      32'(rr_exp));
            @(negedge clk);                              // mandatory IDLE
            chk("rr_gap",   32'(busy),     32'h0);
            if (t == 3) req = 4'b0000;
        end

        // ---- early drop: req and wdata change right after grant ----
        req_we[0]             = 1'b1;
        req_addr[0*AW +: AW]  = 4'h7;
        req_wdata[0*DW +: DW] = 8'h5A;
        req[0]                = 1'b1;
        @(negedge clk);                                  // ISSUE
        chk("ed_gnt",     32'(gnt),      32'h1);
        req[0]                = 1'b0;
        req_wdata[0*DW +: DW] = 8'hFF;
        chk("ed_strobe",  32'(io_write), 32'h1);
        chk("ed_wdata",   32'(io_wdata), 32'h5A);
        @(negedge clk);                                  // DONE
        chk("ed_ack",     32'(ack),      32'h1);
        chk("ed_wdata2",  32'(io_wdata), 32'h5A);
        @(negedge clk);                                  // IDLE
        chk("ed_idle",    32'(busy),     32'h0);

        // ---- wrap-around: index 3, then 0 and 3 together ----
        req_we[3]             = 1'b1;
        req_addr[3*AW +: AW]  = 4'hF;
        req_wdata[3*DW +: DW] = 8'hC3;
        req[3]                = 1'b1;
        @(negedge clk);                                  // ISSUE
        chk("wa_gnt3",    32'(gnt),      32'h8);
        chk("wa_addr3",   32'(io_addr),  32'hF);
        @(negedge clk);                                  // DONE
        chk("wa_ack3",    32'(ack),      32'h8);
        req[0] = 1'b1;                                   // 3 keeps req high too
        @(negedge clk);                                  // IDLE
        chk("wa_gap",     32'(gnt),      32'h0);
        @(negedge clk);                                  // ISSUE
        chk("wa_gnt0",    32'(gnt),      32'h1);
        @(negedge clk);                                  // DONE
        chk("wa_ack0",    32'(ack),      32'h1);
        req = 4'b0000;
        @(negedge clk);                                  // IDLE
        chk("wa_idle",    32'(busy),     32'h0);

        // ---- reset in the middle of a read ----
        req_we[1]            = 1'b0;
        req_addr[1*AW +: AW]  = 4'h3;
        req[1]               = 1'b1;
        @(negedge clk);                                  // ISSUE
        chk("mr_strobe",  32'(io_read),  32'h1);
        @(negedge clk);                                  // CAPTURE
        chk("mr_busy",    32'(busy),     32'h1);
        chk("mr_gnt",     32'(gnt),      32'h2);
        reset = 1'b1;
        #1;
        chk("mr_rd",      32'(io_read),  32'h0);
        chk("mr_gnt0",    32'(gnt),      32'h0);
        chk("mr_ack0",    32'(ack),      32'h0);
        chk("mr_busy0",   32'(busy),     32'h0);
        chk("mr_rdata0",  32'(rdata),    32'h0);
        req = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mr_noack",  32'(ack),   32'h0);
            chk("mr_nobusy", 32'(busy),  32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Arbiter and sequencer for the `IO_Handler` register bus. It shares the single `io_addr`/`io_write`/`io_read`/`io_wdata`/`io_rdata` port of `IO_Handler` among `NUM_REQ` requesters, for example a CPU port and a test/DMA port. For each granted request it issues exactly one single-cycle bus strobe, captures read data, and returns a one-cycle acknowledge to the winning requester.

## Interface
- `NUM_REQ`, default 2: number of requesters (2–8).
- `ADDR_W`, default 4: `IO_Handler` register address width.
- `DATA_W`, default 8: register data width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester request, level.
- `req_we`  in  NUM_REQ  per-requester direction: 1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_W  flattened addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  NUM_REQ*DATA_W  flattened write data, same packing.
- `gnt`  out  NUM_REQ  one-hot grant, held from ISSUE through DONE.
- `ack`  out  NUM_REQ  one-hot, one-cycle completion pulse.
- `rdata`  out  DATA_W  captured read data; valid while `ack` is high, held until the next read capture.
- `busy`  out  1  high whenever the state is not IDLE.
- `io_addr`  out  ADDR_W  to `IO_Handler`.
- `io_write`  out  1  write strobe to `IO_Handler`.
- `io_read`  out  1  read strobe to `IO_Handler`.
- `io_wdata`  out  DATA_W  to `IO_Handler`.
- `io_rdata`  in  DATA_W  from `IO_Handler`; valid one cycle after `io_read`.

## Operation
- **FSM states:** IDLE, ISSUE, CAPTURE, DONE.
- **IDLE:**
  - If any `req` bit is set, select a winner per the arbitration policy.
  - Latch the winner's `req_we`, address and wdata into internal registers; set `gnt`.
  - Go to ISSUE. If no request, stay in IDLE.
- **ISSUE:**
  - `io_addr` and `io_wdata` are driven from the latched registers.
  - Assert exactly one of `io_write` or `io_read`, for this cycle only.
  - Next state: DONE for a write, CAPTURE for a read.
- **CAPTURE:** both strobes low. Register `rdata <= io_rdata`. Go to DONE.
- **DONE:**
  - `ack[winner] = 1`.
  - Advance the round-robin pointer to winner+1, wrapping from `NUM_REQ-1` to 0.
  - Clear `gnt`. Go to IDLE.
- **Arbitration (default, round-robin):** search starts at the pointer. The first set `req` bit at index pointer, pointer+1, … (mod `NUM_REQ`) wins. Pointer reset value is 0.
- **Inputs after grant:**
  - Requester inputs are sampled only in IDLE.
  - Changes to `req`, `req_addr` or `req_wdata` after the grant are ignored.
  - Dropping `req` after the grant does not abort the transaction; `ack` still pulses.
- **Requester protocol:** a requester holds `req` until it sees `ack`. Keeping `req` high in the `ack` cycle means a new request, arbitrated in the following IDLE cycle.
- **Write ack:** `rdata` is unchanged on write acknowledges.
- **Address range:** addresses are passed through unchecked. Out-of-range decode is `IO_Handler`'s responsibility.
- **Output widths:** `io_addr` and `io_wdata` hold their last driven values in IDLE. They are not zeroed.

## Timing
- **Reset values:**
  - `gnt`, `ack`, `busy`, `io_write`, `io_read` = 0.
  - `io_addr`, `io_wdata`, `rdata` = 0.
  - State = IDLE, pointer = 0.
- **Reset mid-transaction:** asynchronous. Strobes, `gnt`, `ack` and `busy` drop immediately with no `ack` issued. The transaction is lost; the requester must re-request.
- **Write latency** (`req` first seen in IDLE at cycle 0):
  - `io_write` high in cycle 1.
  - `ack` high in cycle 2.
  - Earliest next grant in cycle 3.
- **Read latency:**
  - `io_read` high in cycle 1.
  - `io_rdata` sampled at the end of cycle 2.
  - `ack` with valid `rdata` in cycle 3.
- **Throughput:** one transaction per 3 cycles (write) or 4 cycles (read). The mandatory IDLE cycle separates all transactions.
- **Strobe guarantee:** never more than one strobe per transaction. `io_write` and `io_read` are never high together.

## Configuration
- `IO_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins. The pointer is not implemented.
  - Undefined (default): round-robin as described in Operation.
- All other behaviour and timing are identical in both builds.

## Test plan
- **Reset:** assert `reset` mid-read (state CAPTURE) → `io_read`=0, `gnt`=0, `ack`=0, `busy`=0 within the same cycle; no `ack` after release.
- **Single write:** req[0], we=1, addr=4'h2, wdata=8'hA5 → `io_write`=1 for exactly one cycle with `io_addr`=2 and `io_wdata`=A5; `ack[0]` two cycles after the request is seen.
- **Single read:** req[1], we=0, addr=4'h1, model returns 8'h3C one cycle after `io_read` → `ack[1]` in cycle 3 with `rdata`=3C.
- **Round-robin fairness:** req=2'b11 held continuously → grants alternate 0,1,0,1; each transaction separated by one IDLE cycle. With `IO_ARB_FIXED_PRIO_EN` defined → requester 0 always wins.
- **Early drop:** deassert req[0] and change `req_wdata` the cycle after the grant → the original wdata is written and `ack[0]` still pulses.
- **Wrap-around:** `NUM_REQ`=4, request only index 3, then only index 0 → the pointer wraps to 0 and index 0 is granted without an extra idle gap.
